// File: rtl/barrel_multiplication.sv
// barrel_multiplication
// Registered signed multiply-by-power-of-two: y = x * 2^shift_n for an 8-bit
// two's-complement operand, built from a four-stage logarithmic barrel
// shifter (1, 2, 4, 8 bits). overflow flags products outside [-128, 127].
// One result per clock, one cycle of latency, synchronous active-high reset.
//
// Build option: define BARREL_MULT_SATURATE_EN to clamp overflowed results
// to 0x7F / 0x80. Without it, overflowed results wrap (low 8 bits of x << n).
// The overflow flag is identical in both builds.

module barrel_multiplication (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  input  logic [3:0] shift_n,
  output logic [7:0] y,
  output logic       overflow
);

  // Sign of the operand; every bit above bit 7 of the true product equals it.
  logic       sign;

  // Intermediate values after each shifter stage.
  logic [7:0] stage1;
  logic [7:0] stage2;
  logic [7:0] stage3;
  logic [7:0] stage4;

  // Per-stage flags: some discarded bit differed from the sign.
  logic       lost1;
  logic       lost2;
  logic       lost3;
  logic       lost4;

  logic       ovf_next;
  logic [7:0] y_next;

  assign sign = x[7];

  // Shifter stages: each shifts left by its power of two when its control bit
  // is set, zero-fills the vacated LSBs and records whether the bits pushed
  // off the top carried information beyond the sign.
  always_comb begin
    stage1 = x;
    stage2 = 8'h00;
    stage3 = 8'h00;
    stage4 = 8'h00;
    lost1  = 1'b0;
    lost2  = 1'b0;
    lost3  = 1'b0;
    lost4  = 1'b0;

    if (shift_n[0]) begin
      stage1 = {x[6:0], 1'b0};
      lost1  = (x[7] != sign);
    end

    stage2 = stage1;
    if (shift_n[1]) begin
      stage2 = {stage1[5:0], 2'b00};
      lost2  = (stage1[7:6] != {2{sign}});
    end

    stage3 = stage2;
    if (shift_n[2]) begin
      stage3 = {stage2[3:0], 4'h0};
      lost3  = (stage2[7:4] != {4{sign}});
    end

    stage4 = stage3;
    if (shift_n[3]) begin
      // An 8-bit shift discards the whole word.
      stage4 = 8'h00;
      lost4  = (stage3 != {8{sign}});
    end
  end

  // Overflow when any discarded bit, or the surviving sign bit, disagrees with
  // the operand sign; then pick the wrapped or saturated result.
  always_comb begin
    ovf_next = lost1 | lost2 | lost3 | lost4 | (stage4[7] != sign);
    y_next   = stage4;
`ifdef BARREL_MULT_SATURATE_EN
    if (ovf_next) begin
      // Overflow implies x is nonzero, so the sign alone picks the rail.
      y_next = sign ? 8'h80 : 8'h7F;
    end
`endif
  end

  // Output register; reset takes priority over new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      y        <= 8'h00;
      overflow <= 1'b0;
    end else begin
      y        <= y_next;
      overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_barrel_multiplication.sv
// Testbench for barrel_multiplication: directed steps plus a random stream.
// Expected results come from an integer reference model, queued when the
// stimulus is applied and compared after the edge that registers it.

module tb_barrel_multiplication;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] x = 8'h00;
  logic [3:0] shift_n = 4'h0;
  logic [7:0] y;
  logic       overflow;

  typedef struct {
    logic [7:0] y;
    logic       ovf;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  barrel_multiplication dut (
    .clk(clk),
    .rst(rst),
    .x(x),
    .shift_n(shift_n),
    .y(y),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic r, input logic [7:0] xv,
                                 input logic [3:0] sv, input string tag);
    exp_t        e;
    int          p;
    logic [22:0] wide;
    e.tag = tag;
    if (r) begin
      e.y   = 8'h00;
      e.ovf = 1'b0;
      return e;
    end
    p     = int'($signed(xv)) * (1 << sv);
    wide  = {15'b0, xv} << sv;
    e.ovf = (p > 127) || (p < -128);
    if (!e.ovf)
      e.y = p[7:0];
    else begin
`ifdef BARREL_MULT_SATURATE_EN
      e.y = xv[7] ? 8'h80 : 8'h7F;
`else
      e.y = wide[7:0];
`endif
    end
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    n_cmp++;
    assert (exp_q.size() > 0)
    else begin
      n_err++;
      $error("FAIL scoreboard_empty: queue size %0d, required >0", exp_q.size());
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (y === e.y)
      else begin
        n_err++;
        $error("FAIL %s y: got %h, expected %h", e.tag, y, e.y);
      end
      n_cmp++;
      assert (overflow === e.ovf)
      else begin
        n_err++;
        $error("FAIL %s overflow: got %b, expected %b", e.tag, overflow, e.ovf);
      end
    end
  endtask

  // Apply one input set, queue its expectation, check after the sampling edge.
  task automatic step(input logic r, input logic [7:0] xv,
                      input logic [3:0] sv, input string tag);
    rst     = r;
    x       = xv;
    shift_n = sv;
    exp_q.push_back(model(r, xv, sv, tag));
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // Reset held with live data on the inputs.
    step(1'b1, 8'h55, 4'd3, "reset0");
    step(1'b1, 8'h55, 4'd3, "reset1");
    step(1'b0, 8'h55, 4'd3, "reset_release");
    step(1'b1, 8'h7F, 4'd0, "reset_priority");

    // Negative sweep without overflow.
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 25; c++)
        step(1'b0, 8'hF1, s[3:0], "neg_sweep");

    // Negative overflow.
    for (int s = 4; s < 8; s++)
      step(1'b0, 8'hF1, s[3:0], "neg_ovf");

    // Boundaries.
    step(1'b0, 8'h80, 4'd0, "min_no_shift");
    step(1'b0, 8'h40, 4'd1, "pos_edge_ovf");
    step(1'b0, 8'hC0, 4'd1, "neg_edge_ok");
    step(1'b0, 8'h7F, 4'd0, "max_no_shift");
    step(1'b0, 8'hFF, 4'd7, "minus1_s7");
    step(1'b0, 8'hFF, 4'd8, "minus1_s8");

    // Large shifts.
    step(1'b0, 8'h00, 4'd15, "zero_s15");
    step(1'b0, 8'h01, 4'd8, "one_s8");
    step(1'b0, 8'h01, 4'd7, "one_s7");
    step(1'b0, 8'h80, 4'd15, "min_s15");

    // Back-to-back random stream.
    for (int i = 0; i < 300; i++)
      step(1'b0, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
